// File: rtl/arashi_mem_arb.sv
// ============================================================================
// arashi_mem_arb
// ----------------------------------------------------------------------------
// Round-robin arbiter for the shared memory read port. Any number of threads
// (a power of two) can request at once. The winning thread keeps its grant for
// a whole burst of up to MAX_BURST beats, and the memory can hold off any beat
// with mem_ready. When a burst ends, that thread becomes the lowest priority.
// If another request is pending, the next grant is issued on the same edge, so
// the port never sits idle between bursts.
//
// Parameters
//   THREAD_NUM_WIDTH  log2 of the thread count (1..5)
//   MAX_BURST         maximum beats per grant (1..15)
//   THREAD_NUM        derived, 1 << THREAD_NUM_WIDTH
//   BURST_WIDTH       derived, width of one burst_len field
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   rstn       in   asynchronous active-low reset
//   avail      in   per-thread read request
//   burst_len  in   per-thread burst length, thread i at [i*BURST_WIDTH +: BURST_WIDTH]
//   mem_ready  in   memory accepts the offered beat this cycle
//   r_ena      out  one-hot grant, zero while r_valid is low
//   r_valid    out  a beat is offered to memory
//   r_tid      out  index of the granted thread (holds its value while idle)
//   r_last     out  the offered beat is the last one of the burst
// ============================================================================
module arashi_mem_arb #(
    parameter int unsigned  THREAD_NUM_WIDTH = 3,
    parameter int unsigned  MAX_BURST        = 4,
    localparam int unsigned THREAD_NUM       = 1 << THREAD_NUM_WIDTH,
    localparam int unsigned BURST_WIDTH      = $clog2(MAX_BURST + 1)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [THREAD_NUM-1:0]             avail,
    input  logic [THREAD_NUM*BURST_WIDTH-1:0] burst_len,
    input  logic                              mem_ready,
    output logic [THREAD_NUM-1:0]             r_ena,
    output logic                              r_valid,
    output logic [THREAD_NUM_WIDTH-1:0]       r_tid,
    output logic                              r_last
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e                      r_state;
    logic [THREAD_NUM_WIDTH-1:0] r_ptr;
    logic [BURST_WIDTH-1:0]      r_beats_left;

    logic [THREAD_NUM_WIDTH-1:0] w_start;
    logic [THREAD_NUM_WIDTH-1:0] w_win;
    logic                        w_found;
    logic [BURST_WIDTH-1:0]      w_raw_len;
    logic [BURST_WIDTH-1:0]      w_eff_len;
    logic                        w_accept;

    assign w_accept = r_valid & mem_ready;

    // While granted, the search that matters is the back-to-back one taken on the
    // last beat, whose pointer is r_tid+1 -- the value r_ptr is being loaded with
    // on that same edge. Using it directly avoids a one-cycle bubble.
    assign w_start = (r_state == StGrant) ? r_tid + THREAD_NUM_WIDTH'(1) : r_ptr;

    // Circular first-set search from w_start; index arithmetic wraps naturally.
    always_comb begin : search
        logic [THREAD_NUM_WIDTH-1:0] idx;
        w_win   = '0;
        w_found = 1'b0;
        idx     = '0;
        for (int i = 0; i < THREAD_NUM; i++) begin
            idx = w_start + THREAD_NUM_WIDTH'(i);
            if (!w_found && avail[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    // Burst length of the winner: 0 means a single beat, oversize values clamp.
    assign w_raw_len = burst_len[w_win*BURST_WIDTH +: BURST_WIDTH];

    always_comb begin
        w_eff_len = w_raw_len;
        if (w_raw_len == '0) begin
            w_eff_len = BURST_WIDTH'(1);
        end else if (w_raw_len > BURST_WIDTH'(MAX_BURST)) begin
            w_eff_len = BURST_WIDTH'(MAX_BURST);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= StIdle;
            r_ptr        <= '0;
            r_beats_left <= '0;
            r_ena        <= '0;
            r_valid      <= 1'b0;
            r_tid        <= '0;
            r_last       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_state      <= StGrant;
                        r_ena        <= THREAD_NUM'(1) << w_win;
                        r_tid        <= w_win;
                        r_valid      <= 1'b1;
                        r_beats_left <= w_eff_len;
                        r_last       <= (w_eff_len == BURST_WIDTH'(1));
                    end
                end
                StGrant: begin
                    // Outputs hold while memory stalls the beat.
                    if (w_accept) begin
                        if (r_beats_left > BURST_WIDTH'(1)) begin
                            r_beats_left <= r_beats_left - BURST_WIDTH'(1);
                            r_last       <= (r_beats_left == BURST_WIDTH'(2));
                        end else begin
                            r_ptr <= r_tid + THREAD_NUM_WIDTH'(1);
                            if (w_found) begin
                                r_ena        <= THREAD_NUM'(1) << w_win;
                                r_tid        <= w_win;
                                r_valid      <= 1'b1;
                                r_beats_left <= w_eff_len;
                                r_last       <= (w_eff_len == BURST_WIDTH'(1));
                            end else begin
                                r_state      <= StIdle;
                                r_ena        <= '0;
                                r_valid      <= 1'b0;
                                r_last       <= 1'b0;
                                r_beats_left <= '0;
                            end
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_arashi_mem_arb.sv
// ============================================================================
// tb_arashi_mem_arb
// ----------------------------------------------------------------------------
// Bench for arashi_mem_arb (8 threads, MAX_BURST=4). The stimulus process pushes
// the expected beat stream into a queue; a monitor compares every offered beat
// (r_valid high) against the queue head and checks the output invariants.
// ============================================================================
module tb_arashi_mem_arb;

    localparam int unsigned TW = 3;
    localparam int unsigned N  = 8;
    localparam int unsigned BW = 3;

    logic          clk;
    logic          rstn;
    logic [N-1:0]  avail;
    logic [N*BW-1:0] burst_len;
    logic          mem_ready;
    logic [N-1:0]  r_ena;
    logic          r_valid;
    logic [TW-1:0] r_tid;
    logic          r_last;

    arashi_mem_arb #(
        .THREAD_NUM_WIDTH (TW),
        .MAX_BURST        (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .avail     (avail),
        .burst_len (burst_len),
        .mem_ready (mem_ready),
        .r_ena     (r_ena),
        .r_valid   (r_valid),
        .r_tid     (r_tid),
        .r_last    (r_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] tid;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int tid, input bit last);
        exp_t e;
        e.tid  = TW'(tid);
        e.last = last;
        exp_q.push_back(e);
    endtask

    function automatic logic [N*BW-1:0] all_len(input int v);
        logic [N*BW-1:0] r;
        for (int i = 0; i < N; i++) r[i*BW +: BW] = BW'(v);
        return r;
    endfunction

    // Monitor: scoreboard compare of each offered beat plus invariants.
    always @(negedge clk) begin
        if (rstn) begin
            check("inv_ena", 32'(r_ena), r_valid ? 32'(8'd1 << r_tid) : 32'd0);
            check("inv_last", 32'(r_last & ~r_valid), 32'd0);
            if (r_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got tid %0d last %0b, expected no beat (t=%0t)",
                             r_tid, r_last, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat_tid", 32'(r_tid), 32'(e.tid));
                    check("beat_ena", 32'(r_ena), 32'(8'd1 << e.tid));
                    check("beat_last", 32'(r_last), 32'(e.last));
                end
            end
        end
    end

    task automatic check_idle(input string name);
        check({name, "_valid"}, 32'(r_valid), 32'd0);
        check({name, "_ena"}, 32'(r_ena), 32'd0);
        check({name, "_last"}, 32'(r_last), 32'd0);
    endtask

    // Called at posedge+2; pulses reset and checks the asynchronous clear.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check_idle("rst_async");
        check("rst_async_tid", 32'(r_tid), 32'd0);
        @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        avail     = '0;
        burst_len = '0;
        mem_ready = 1'b0;

        // 1: reset values, held through reset even with requests present.
        #1;
        check_idle("rst_init");
        check("rst_init_tid", 32'(r_tid), 32'd0);
        @(posedge clk);
        #2 avail = 8'hFF;
        @(posedge clk);
        #2;
        check_idle("rst_hold");
        avail = '0;
        rstn  = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_idle("rst_release_idle");
        check("rst_release_tid", 32'(r_tid), 32'd0);

        // 2: rotation over all 8 threads, single-beat bursts.
        do_reset();
        burst_len = all_len(1);
        mem_ready = 1'b1;
        avail     = 8'hFF;
        for (int i = 0; i < 8; i++) push(i, 1'b1);
        push(0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #2 check("rot_nodrop", 32'(r_valid), 32'd1);
        end
        avail = '0;
        @(posedge clk);
        #2 check_idle("rot_end");

        // 3: fairness between threads 0 and 7, then thread 0 alone.
        do_reset();
        avail = 8'h81;
        push(0, 1'b1); push(7, 1'b1); push(0, 1'b1); push(7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2 check("fair_nodrop", 32'(r_valid), 32'd1);
        end
        avail = 8'h01;
        push(0, 1'b1); push(0, 1'b1); push(0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2 check("single_nodrop", 32'(r_valid), 32'd1);
        end
        avail = '0;
        @(posedge clk);
        #2 check_idle("fair_end");

        // 4: backpressure, 3-beat burst with a stall on the second offered cycle.
        do_reset();
        burst_len = all_len(3);
        avail     = 8'h04;
        mem_ready = 1'b1;
        push(2, 1'b0); push(2, 1'b0); push(2, 1'b0); push(2, 1'b1);
        @(posedge clk);
        #2 avail = '0;          // mid-burst drop is ignored
        mem_ready = 1'b1;
        @(posedge clk);
        #2 mem_ready = 1'b0;
        @(posedge clk);
        #2 mem_ready = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        check_idle("bp_end");
        check("bp_end_tid_hold", 32'(r_tid), 32'd2);

        // 5: length edges -- 0 means one beat, 7 clamps to 4.
        do_reset();
        burst_len = '0;
        avail     = 8'h01;
        push(0, 1'b1);
        @(posedge clk);
        #2 avail = '0;
        @(posedge clk);
        #2 check_idle("len0_end");
        burst_len = '0;
        burst_len[3*BW +: BW] = 3'd7;
        avail = 8'h08;
        push(3, 1'b0); push(3, 1'b0); push(3, 1'b0); push(3, 1'b1);
        @(posedge clk);
        #2 avail = '0;
        repeat (4) @(posedge clk);
        #2 check_idle("len7_end");

        // 6: reset during beat 2 of a 4-beat burst, then restart from thread 0.
        do_reset();
        burst_len = all_len(4);
        avail     = 8'h81;
        push(0, 1'b0); push(0, 1'b0);
        @(posedge clk);         // grant, beat 1 offered
        @(posedge clk);         // beat 1 accepted, beat 2 offered
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_idle("midrst_async");
        check("midrst_tid", 32'(r_tid), 32'd0);
        @(posedge clk);
        #2;
        push(0, 1'b0); push(0, 1'b0); push(0, 1'b0); push(0, 1'b1);
        rstn = 1'b1;
        @(posedge clk);
        #2 avail = '0;
        check("midrst_regrant_valid", 32'(r_valid), 32'd1);
        repeat (4) @(posedge clk);
        #2 check_idle("midrst_end");

        repeat (2) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
